// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seqdet_pkg;

    localparam int SEQDET_PAT_W = 8;
    localparam int SEQDET_LEN_W = 4;
    localparam int SEQDET_CNT_W = 16;

    // A length is usable only when it selects at least one bit and fits the pattern register.
    function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
        return (len != 0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating event counter; a clear coinciding with an increment leaves the count at 1.
module seqdet_sat_cnt
    import seqdet_pkg::*;
#(
    parameter int CNT_W = SEQDET_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Run-time configurable serial pattern detector with saturating match counter.
// Define SEQDET_MASK_EN to add a per-bit don't-care mask port.
module seq_pattern_detector
    import seqdet_pkg::*;
#(
    parameter int PAT_W = SEQDET_PAT_W,
    parameter int LEN_W = SEQDET_LEN_W,
    parameter int CNT_W = SEQDET_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    input  logic             data_valid,
    input  logic             data_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count
`ifdef SEQDET_MASK_EN
    ,
    input  logic [PAT_W-1:0] mask
`endif
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             match_q, match_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;

    logic [PAT_W-1:0] hist_n;
    logic [LEN_W-1:0] fill_n;
    logic [PAT_W-1:0] len_mask;
    logic [PAT_W-1:0] care;
    logic             accept;
    logic             hit;

    // Bit gi takes part in the compare only when it lies inside the active length.
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_len_mask
        assign len_mask[gi] = (LEN_W'(gi) < len_q);
    end

`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;
    assign care = len_mask & ~mask_q;
`else
    assign care = len_mask;
`endif

    assign accept = data_valid && !cfg_load;
    assign hist_n = {hist_q[PAT_W-2:0], data_in};
    assign fill_n = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + LEN_W'(1);

    // The fill gate keeps stale or cleared history from producing a match.
    assign hit = accept && (len_q != '0) && (fill_n >= len_q)
                 && (((hist_n ^ pat_q) & care) == '0);

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
`ifdef SEQDET_MASK_EN
        mask_d  = mask_q;
`endif
        if (cfg_load) begin
            pat_d  = pattern;
            len_d  = len_ok(32'(pat_len), 32'(PAT_W)) ? pat_len : '0;
            ovl_d  = overlap_en;
            hist_d = '0;
            fill_d = '0;
`ifdef SEQDET_MASK_EN
            mask_d = mask;
`endif
        end else if (data_valid) begin
            hist_d  = hist_n;
            match_d = hit;
            fill_d  = (hit && !ovl_q) ? '0 : fill_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
`ifdef SEQDET_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
`ifdef SEQDET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    seqdet_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (cnt_clr),
        .count (match_count)
    );

    assign match = match_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: stimulus queues expectations, a monitor compares.
module tb_seq_pattern_detector;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [LEN_W-1:0] pat_len = '0;
    logic             overlap_en = 1'b0;
    logic             data_valid = 1'b0;
    logic             data_in = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             match;
    logic [CNT_W-1:0] match_count;
`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0] mask = '0;
`endif

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    string q_nm[$];
    bit    q_m[$];
    int    q_c[$];

    seq_pattern_detector #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_load    (cfg_load),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .overlap_en  (overlap_en),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_count (match_count)
`ifdef SEQDET_MASK_EN
        ,
        .mask        (mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input string nm, input logic ld, input logic dv, input logic din,
                       input logic clr, input bit em);
        @(negedge clk);
        cfg_load   = ld;
        data_valid = dv;
        data_in    = din;
        cnt_clr    = clr;
        if (clr)
            exp_cnt = em ? 1 : 0;
        else if (em && exp_cnt < CNT_MAX)
            exp_cnt = exp_cnt + 1;
        q_nm.push_back(nm);
        q_m.push_back(em);
        q_c.push_back(exp_cnt);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        pattern    = p;
        pat_len    = l;
        overlap_en = o;
        cyc("cfg", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // bits and hits are read first-received at index n-1.
    task automatic stream(input string nm, input logic [15:0] bits, input logic [15:0] hits,
                          input int n);
        for (int i = n - 1; i >= 0; i--)
            cyc(nm, 1'b0, 1'b1, bits[i], 1'b0, hits[i]);
    endtask

    task automatic clear_cnt();
        cyc("clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (q_m.size() != 0) begin
            string nm;
            bit    em;
            int    ec;
            nm = q_nm.pop_front();
            em = q_m.pop_front();
            ec = q_c.pop_front();
            $display("txn %-10s match=%0b count=%0d (exp %0b/%0d)", nm, match, match_count, em, ec);
            chk({nm, ".match"}, int'(match), int'(em));
            chk({nm, ".count"}, int'(match_count), ec);
        end
    end

    initial begin
        // Reset state, with noisy inputs present.
        data_valid = 1'b1;
        data_in    = 1'b1;
        cfg_load   = 1'b1;
        pattern    = 8'hFF;
        pat_len    = 4'd1;
        repeat (3) @(negedge clk);
        chk("rst.match", int'(match), 0);
        chk("rst.count", int'(match_count), 0);
        cfg_load   = 1'b0;
        data_valid = 1'b0;
        rst_n      = 1'b1;

        // Overlapping detection of 10110.
        load(8'b10110, 4'd5, 1'b1);
        stream("ovl", 16'b10110110, 16'b00001001, 8);
        cyc("ovl_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_cnt();

        // Non-overlapping: the final 10110 arrives with only 3 fresh bits.
        load(8'b10110, 4'd5, 1'b0);
        stream("novl", 16'b10110110, 16'b00001000, 8);
        clear_cnt();

        // Gaps in data_valid with a misleading data_in.
        load(8'b10110, 4'd5, 1'b1);
        stream("gap", 16'b10, 16'b00, 2);
        repeat (3) cyc("gap_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stream("gap", 16'b110, 16'b001, 3);
        clear_cnt();

        // Reload mid-stream; the bit offered during the load cycle is dropped.
        load(8'b10110, 4'd5, 1'b1);
        stream("reld_pre", 16'b101, 16'b000, 3);
        pattern = 8'b11;
        pat_len = 4'd2;
        cyc("reld_load", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        stream("reld", 16'b111, 16'b011, 3);
        clear_cnt();

        // Invalid lengths disable detection; PAT_W itself is the largest valid length.
        load(8'hFF, 4'd0, 1'b1);
        stream("len0", 16'hFF, 16'h0, 8);
        load(8'hFF, 4'd9, 1'b1);
        stream("len9", 16'hFFFF, 16'h0, 16);
        load(8'hFF, 4'd8, 1'b1);
        stream("len8", 16'h3FF, 16'b0000000111, 10);
        clear_cnt();

        // Saturation, then clear coinciding with a hit.
        load(8'b11, 4'd2, 1'b1);
        stream("sat", 16'b111111, 16'b011111, 6);
        cyc("clr_hit", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        clear_cnt();

`ifdef SEQDET_MASK_EN
        mask = 8'b00100;
        load(8'b10110, 4'd5, 1'b0);
        stream("mask", 16'b1001010110, 16'b0000100001, 10);
        mask = '0;
        clear_cnt();
`endif

        // Asynchronous reset while match is high.
        load(8'b10110, 4'd5, 1'b1);
        stream("pre_rst", 16'b10110, 16'b00001, 5);
        @(negedge clk);
        data_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.match", int'(match), 0);
        chk("async_rst.count", int'(match_count), 0);
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stream("post_rst", 16'b10110110, 16'h0, 8);
        cyc("end_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && q_m.size() != 0; i++) @(posedge clk);
        #2;
        chk("drain", q_m.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector.
- Pattern, length and overlap mode are run-time configurable; a saturating match counter is included.
- Next generation of the fixed one-hot "10110" detectors. Sits on the serial data path after any deserialiser/sync stage and feeds a status/interrupt block.
- One clock domain. Single-bit serial input, qualified by a valid strobe.

Parameters:
- PAT_W, 8, maximum pattern length in bits (2..32).
- LEN_W, 4, width of pattern-length field; must satisfy 2^LEN_W > PAT_W.
- CNT_W, 16, match counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  pulse: latch pattern/pat_len/overlap_en and restart detection.
- pattern  in  PAT_W  target pattern. Bit [pat_len-1] is received first; bit [0] is received last.
- pat_len  in  LEN_W  active pattern length, 1..PAT_W.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- data_valid  in  1  data_in is sampled only when this is 1.
- data_in  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_count.
- match  out  1  one-cycle pulse: pattern completed on the previous accepted bit.
- match_count  out  CNT_W  saturating count of matches.
- mask  in  PAT_W  per-bit don't-care mask (only with SEQDET_MASK_EN).

Behaviour:
- Reset (async, active-low): all of the following clear to 0.
  - history shift register (PAT_W bits)
  - fill counter
  - match, match_count
  - pat_q, len_q, ovl_q
  - This leaves the detector disabled: len_q = 0 never matches.
- cfg_load = 1:
  - pat_q <= pattern, len_q <= pat_len, ovl_q <= overlap_en.
  - history, fill and match are cleared.
  - Any data_valid in the same cycle is dropped (cfg_load has priority).
  - pat_len = 0 or pat_len > PAT_W: latch len_q = 0, detector disabled.
  - match_count is untouched.
- Accepted bit (data_valid = 1, cfg_load = 0):
  - hist_n = {history[PAT_W-2:0], data_in}.
  - fill_n = min(fill + 1, PAT_W).
  - hit = (len_q != 0) && (fill_n >= len_q) && (hist_n[len_q-1:0] == pat_q[len_q-1:0]).
- Register updates on an accepted bit:
  - history <= hist_n.
  - match <= hit.
  - If hit and ovl_q = 0: fill <= 0, so the next match needs len_q fresh bits. History is kept, but the fill gate masks it.
  - Otherwise: fill <= fill_n. In overlap mode, pattern bits may be shared between matches.
- Latency: match is registered and asserts exactly one clk after the edge that accepted the final pattern bit. It is high for one cycle.
- No accepted bit in a cycle: match <= 0; history and fill hold.
- match_count:
  - Increments by 1 in the same edge that sets match.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr alone: count <= 0.
  - cnt_clr with hit in the same cycle: count <= 1, so no match is lost.
- Before fill reaches len_q after reset or cfg_load, no match is possible, even if stale history bits would compare equal.
- Reset asserted mid-pattern: immediate clear; no match pulse after release.
- Changing pattern/pat_len/overlap_en without cfg_load has no effect.

Optional Feature:
- Macro: SEQDET_MASK_EN.
- Defined:
  - mask port exists and is latched into mask_q on cfg_load.
  - A mask_q bit of 1 makes the corresponding pattern bit don't-care.
  - Comparison: ((hist_n ^ pat_q) & ~mask_q)[len_q-1:0] == 0.
  - Reset value of mask_q is 0.
- Undefined: no mask port and no mask_q; exact compare only.

Decomposition:
- Package seqdet_pkg holds:
  - default constants SEQDET_PAT_W = 8, SEQDET_LEN_W = 4, SEQDET_CNT_W = 16.
  - function len_ok(len) returning the 1..PAT_W range check.
- One sub-module, seqdet_sat_cnt: parametrised CNT_W saturating counter with inc and clr inputs and the clr+inc = 1 rule.
- The detector core stays in seq_pattern_detector.

Test Plan:
- Overlap mode:
  - Stimulus: cfg pattern = 8'b10110, pat_len = 5, overlap_en = 1; stream 1,0,1,1,0,1,1,0 with data_valid = 1 every cycle.
  - Required: match pulses one cycle after bits 5 and 8; match_count = 2.
- Non-overlap mode:
  - Stimulus: same as the overlap test with overlap_en = 0.
  - Required: single match after bit 5; match_count = 1.
- Valid gaps:
  - Stimulus: same pattern, data_valid deasserted for 3 cycles between bits 2 and 3.
  - Required: match still occurs one cycle after bit 5 is accepted; no pulses during the gaps.
- Reconfiguration:
  - Stimulus: cfg_load mid-stream after bits "101", with data_valid = 1 in the same cycle; new pattern 2'b11, pat_len = 2; then bits 1,1,1 (overlap_en = 1).
  - Required: the load-cycle bit is ignored; matches after new bits 2 and 3; pat_len = 0 or 9 gives no matches.
- Counter:
  - Stimulus: CNT_W = 2, repeated overlap pattern 1,1 (pat_len = 2) for 6 bits.
  - Required: count saturates at 3.
  - Stimulus: cnt_clr asserted in the same cycle as a hit.
  - Required: count = 1.
- Mask (with SEQDET_MASK_EN):
  - Stimulus: pattern 10110, mask 00100; stream 10010 then 10110.
  - Required: both streams match.
  - Stimulus: async reset asserted mid-stream.
  - Required: all outputs 0 immediately.
